can_rx_framer: RTL

Receive-side frame sequencer for classical CAN standard (11-bit ID) frames. Consumes one sampled bus bit per `bit_valid` strobe from the bit-timing stage, removes stuff bits, tracks frame fields, and checks stuffing and fixed-form bits. Feeds the serial capture stage directly downstream: it drives that stage's `init`, `id_en`, `data_en` and `bit_in`.

---
 rtl/can_pkg.sv | 26 ++
 rtl/can_destuff.sv | 59 +++++
 rtl/can_rx_framer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types and field lengths for the CAN receive framer.
package can_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_RTR,
        ST_IDE,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_WAIT_IDLE
    } canState_e;

    localparam int ID_LEN    = 11;
    localparam int DLC_LEN   = 4;
    localparam int CRC_LEN   = 15;
    localparam int EOF_LEN   = 7;
    localparam int STUFF_RUN = 5;

endpackage

// File: rtl/can_destuff.sv
// Run-length tracker that strips CAN stuff bits and flags stuffing violations.
module can_destuff
    import can_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic restart_i,
    input  logic bit_valid_i,
    input  logic rx_bit_i,
    output logic bit_valid_o,
    output logic bit_o,
    output logic stuff_err_o
);

    logic [2:0] runCnt_q, runCnt_d;
    logic       runVal_q, runVal_d;

    // A restart models the SOF bit itself: one dominant bit already in the run.
    always_comb begin
        runCnt_d    = runCnt_q;
        runVal_d    = runVal_q;
        bit_valid_o = 1'b0;
        bit_o       = rx_bit_i;
        stuff_err_o = 1'b0;
        if (restart_i) begin
            runCnt_d = 3'd1;
            runVal_d = 1'b0;
        end else if (en_i && bit_valid_i) begin
            if (runCnt_q == 3'(STUFF_RUN)) begin
                if (rx_bit_i != runVal_q) begin
                    runCnt_d = 3'd1;
                    runVal_d = rx_bit_i;
                end else begin
                    stuff_err_o = 1'b1;
                end
            end else begin
                bit_valid_o = 1'b1;
                if (rx_bit_i == runVal_q) begin
                    runCnt_d = runCnt_q + 3'd1;
                end else begin
                    runCnt_d = 3'd1;
                    runVal_d = rx_bit_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            runCnt_q <= 3'd0;
            runVal_q <= 1'b0;
        end else begin
            runCnt_q <= runCnt_d;
            runVal_q <= runVal_d;
        end
    end

endmodule

// File: rtl/can_rx_framer.sv
// Receive-side sequencer for classical CAN base frames; walks the frame fields on
// destuffed bits and drives the downstream serial capture stage.
module can_rx_framer
    import can_pkg::*;
#(
    parameter int IDLE_BITS = 11,
    parameter int MAX_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid_i,
    input  logic        rx_bit_i,
    output logic        init_o,
    output logic        id_en_o,
    output logic        data_en_o,
    output logic        bit_out_o,
    output logic        rtr_o,
    output logic [3:0]  dlc_o,
    output logic [14:0] crc_rx_o,
    output logic        frame_ok_o,
    output logic        stuff_err_o,
    output logic        form_err_o
);

    localparam int            RW       = $clog2(IDLE_BITS + 1);
    localparam logic [RW-1:0] IDLE_CNT = RW'(IDLE_BITS);
    localparam logic [3:0]    MAX_NIB  = 4'(MAX_BYTES);

    canState_e     state_q, state_d;
    logic [RW-1:0] recCnt_q, recCnt_d;
    logic [7:0]    fieldCnt_q, fieldCnt_d;
    logic [7:0]    dataBits_q, dataBits_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [14:0]   crc_q, crc_d;
    logic          init_q, init_d, idEn_q, idEn_d, dataEn_q, dataEn_d, bitOut_q, bitOut_d;
    logic          frameOk_q, frameOk_d, stuffErr_q, stuffErr_d, formErr_q, formErr_d;
    logic          sof, dsEn, dsValid, dsBit, dsErr;
    logic [3:0]    dlcNext, dataBytes;

    assign sof  = bit_valid_i && !rx_bit_i && (state_q == ST_IDLE) && (recCnt_q == IDLE_CNT);
    assign dsEn = state_q inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL};

    can_destuff uDestuff (
        .clk         (clk),
        .rst         (rst),
        .en_i        (dsEn),
        .restart_i   (sof),
        .bit_valid_i (bit_valid_i),
        .rx_bit_i    (rx_bit_i),
        .bit_valid_o (dsValid),
        .bit_o       (dsBit),
        .stuff_err_o (dsErr)
    );

    // Stuffed fields advance only on destuffed bits; ACK onwards uses raw samples.
    always_comb begin
        state_d    = state_q;
        recCnt_d   = recCnt_q;
        fieldCnt_d = fieldCnt_q;
        dataBits_d = dataBits_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        crc_d      = crc_q;
        init_d     = 1'b0;
        idEn_d     = 1'b0;
        dataEn_d   = 1'b0;
        bitOut_d   = 1'b0;
        frameOk_d  = 1'b0;
        stuffErr_d = 1'b0;
        formErr_d  = 1'b0;
        dlcNext    = {dlc_q[2:0], dsBit};
        if (rtr_q)                  dataBytes = 4'd0;
        else if (dlcNext > MAX_NIB) dataBytes = MAX_NIB;
        else                        dataBytes = dlcNext;

        if (bit_valid_i) begin
            if (!rx_bit_i)                recCnt_d = '0;
            else if (recCnt_q != IDLE_CNT) recCnt_d = recCnt_q + RW'(1);

            case (state_q)
                ST_IDLE: begin
                    if (sof) begin
                        init_d     = 1'b1;
                        rtr_d      = 1'b0;
                        dlc_d      = 4'd0;
                        crc_d      = 15'd0;
                        fieldCnt_d = 8'd0;
                        state_d    = ST_ID;
                    end else if (!rx_bit_i) begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: if (recCnt_d == IDLE_CNT) state_d = ST_IDLE;
                ST_ACK:       state_d = ST_ACK_DEL;
                ST_ACK_DEL: begin
                    if (!rx_bit_i) begin
                        formErr_d = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else begin
                        fieldCnt_d = 8'd0;
                        state_d    = ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (!rx_bit_i) begin
                        formErr_d = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else if (fieldCnt_q == 8'(EOF_LEN - 1)) begin
                        frameOk_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        fieldCnt_d = fieldCnt_q + 8'd1;
                    end
                end
                default: begin
                    if (dsErr) begin
                        stuffErr_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                    end else if (dsValid) begin
                        case (state_q)
                            ST_ID: begin
                                idEn_d   = 1'b1;
                                bitOut_d = dsBit;
                                if (fieldCnt_q == 8'(ID_LEN - 1)) begin
                                    fieldCnt_d = 8'd0;
                                    state_d    = ST_RTR;
                                end else begin
                                    fieldCnt_d = fieldCnt_q + 8'd1;
                                end
                            end
                            ST_RTR: begin
                                rtr_d   = dsBit;
                                state_d = ST_IDE;
                            end
                            ST_IDE: begin
                                if (dsBit) begin
                                    formErr_d = 1'b1;
                                    state_d   = ST_WAIT_IDLE;
                                end else begin
                                    state_d = ST_R0;
                                end
                            end
                            ST_R0: state_d = ST_DLC;
                            ST_DLC: begin
                                dlc_d = dlcNext;
                                if (fieldCnt_q == 8'(DLC_LEN - 1)) begin
                                    fieldCnt_d = 8'd0;
                                    dataBits_d = {1'b0, dataBytes, 3'b000};
                                    state_d    = (dataBytes == 4'd0) ? ST_CRC : ST_DATA;
                                end else begin
                                    fieldCnt_d = fieldCnt_q + 8'd1;
                                end
                            end
                            ST_DATA: begin
                                dataEn_d = 1'b1;
                                bitOut_d = dsBit;
                                if (fieldCnt_q == dataBits_q - 8'd1) begin
                                    fieldCnt_d = 8'd0;
                                    state_d    = ST_CRC;
                                end else begin
                                    fieldCnt_d = fieldCnt_q + 8'd1;
                                end
                            end
                            ST_CRC: begin
                                crc_d = {crc_q[13:0], dsBit};
                                if (fieldCnt_q == 8'(CRC_LEN - 1)) begin
                                    fieldCnt_d = 8'd0;
                                    state_d    = ST_CRC_DEL;
                                end else begin
                                    fieldCnt_d = fieldCnt_q + 8'd1;
                                end
                            end
                            ST_CRC_DEL: begin
                                if (!dsBit) begin
                                    formErr_d = 1'b1;
                                    state_d   = ST_WAIT_IDLE;
                                end else begin
                                    state_d = ST_ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            recCnt_q   <= '0;
            fieldCnt_q <= 8'd0;
            dataBits_q <= 8'd0;
            rtr_q      <= 1'b0;
            dlc_q      <= 4'd0;
            crc_q      <= 15'd0;
            init_q     <= 1'b0;
            idEn_q     <= 1'b0;
            dataEn_q   <= 1'b0;
            bitOut_q   <= 1'b0;
            frameOk_q  <= 1'b0;
            stuffErr_q <= 1'b0;
            formErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            recCnt_q   <= recCnt_d;
            fieldCnt_q <= fieldCnt_d;
            dataBits_q <= dataBits_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            crc_q      <= crc_d;
            init_q     <= init_d;
            idEn_q     <= idEn_d;
            dataEn_q   <= dataEn_d;
            bitOut_q   <= bitOut_d;
            frameOk_q  <= frameOk_d;
            stuffErr_q <= stuffErr_d;
            formErr_q  <= formErr_d;
        end
    end

    assign init_o      = init_q;
    assign id_en_o     = idEn_q;
    assign data_en_o   = dataEn_q;
    assign bit_out_o   = bitOut_q;
    assign rtr_o       = rtr_q;
    assign dlc_o       = dlc_q;
    assign crc_rx_o    = crc_q;
    assign frame_ok_o  = frameOk_q;
    assign stuff_err_o = stuffErr_q;
    assign form_err_o  = formErr_q;

endmodule
